frame_check: RTL and testbench

- Stream sink that consumes the frames produced by the UART/stream test frame generator.
- Regenerates the expected rotating 16-bit pattern locally and compares it word by word against the received stream.
- Checks frame length against FRAME_LEN and keeps saturating frame, word-error and length-error counters for the test harness and software readback.
- Sits at the receive end of the loopback: link RX stream → frame_check.

---
 rtl/frame_check_if.sv | 15 +
 rtl/frame_check.sv | 147 ++++++++++++++
 tb/tb_frame_check.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/frame_check_if.sv
// Receive-side stream bundle between the link RX path and frame_check.
// Ports: tdata/tkeep/tvalid/tlast run from the source to the sink, and tready runs back.
// The master modport is for the source (bench or link) and the slave modport is for the checker.
interface frame_check_if #(
  parameter int DW = 16
);
  logic [DW-1:0] tdata;
  logic [1:0]    tkeep;
  logic          tvalid;
  logic          tlast;
  logic          tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/frame_check.sv
// Stream sink for test frames. It regenerates the rotating 16-bit pattern and checks each beat
// and the frame length, and it keeps saturating frame/good/word-error/length-error counters.
// Ports: clk, reset (synchronous, active-high), link_up enable, s (slave stream), counters,
// frame_done/frame_ok pulse, and the first_err_* log. The log is built only when
// FRAME_CHECK_ERRLOG_EN is defined; otherwise it is tied to 0.
module frame_check #(
  parameter logic [127:0] PATTERN    = 128'h0123_3210_2222_3333_4444_5555_beaf_dead,
  parameter int           DW         = 16,
  parameter int           FRAME_LEN  = 28,
  parameter int           SKIP_WORDS = 28,
  parameter int           CW         = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           link_up,
  frame_check_if.slave   s,
  output logic [CW-1:0]  frame_cnt,
  output logic [CW-1:0]  good_cnt,
  output logic [CW-1:0]  word_err_cnt,
  output logic [CW-1:0]  len_err_cnt,
  output logic           frame_done,
  output logic           frame_ok,
  output logic           first_err_vld,
  output logic [DW-1:0]  first_err_exp,
  output logic [DW-1:0]  first_err_got,
  output logic [6:0]     first_err_idx
);
  localparam int EW = 3 * 128;
  localparam int SW = $clog2(SKIP_WORDS + 1);

  typedef enum logic {SKIP, RUN} state_t;

  state_t        state, state_nxt;
  logic [EW-1:0] exp_reg;
  logic [SW-1:0] skip_cnt;
  logic [6:0]    beat_idx;
  logic          frame_err;

  logic          tready;
  logic          beat;
  logic          rotate;
  logic          skip_last;
  logic [DW-1:0] exp_word;
  logic          beat_err;
  logic          len_bad;
  logic          close_ok;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign exp_word = exp_reg[DW-1:0];
  assign beat_err = (s.tdata != exp_word) || (s.tkeep != 2'b11);
  assign len_bad  = (beat_idx != 7'(FRAME_LEN - 1));
  // The closing beat's own error has not reached frame_err yet, so it is folded in here.
  assign close_ok = !(frame_err || beat_err || len_bad);
  assign s.tready = tready && !reset;

  always_ff @(posedge clk) begin
    if (reset) state <= SKIP;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tready    = 1'b0;
    beat      = 1'b0;
    rotate    = 1'b0;
    skip_last = 1'b0;
    unique case (state)
      SKIP: begin
        if (link_up) begin
          rotate = 1'b1;
          if (skip_cnt == SW'(1)) begin
            skip_last = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        tready = link_up;
        beat   = link_up && s.tvalid;
        if (beat) begin
          rotate = 1'b1;
          if (s.tlast) state_nxt = SKIP;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_reg      <= {3{PATTERN}};
      skip_cnt     <= SW'(SKIP_WORDS);
      beat_idx     <= '0;
      frame_err    <= 1'b0;
      frame_cnt    <= '0;
      good_cnt     <= '0;
      word_err_cnt <= '0;
      len_err_cnt  <= '0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (rotate) exp_reg <= {exp_reg[DW-1:0], exp_reg[EW-1:DW]};
      if (rotate && state == SKIP) skip_cnt <= skip_cnt - 1'b1;
      if (skip_last) beat_idx <= '0;
      if (beat) begin
        if (beat_idx != 7'h7f) beat_idx <= beat_idx + 1'b1;
        if (beat_err) word_err_cnt <= sat_inc(word_err_cnt);
        if (s.tlast) begin
          frame_done <= 1'b1;
          frame_ok   <= close_ok;
          frame_cnt  <= sat_inc(frame_cnt);
          if (close_ok) good_cnt <= sat_inc(good_cnt);
          if (len_bad)  len_err_cnt <= sat_inc(len_err_cnt);
          frame_err  <= 1'b0;
          skip_cnt   <= SW'(SKIP_WORDS);
        end else if (beat_err) begin
          frame_err <= 1'b1;
        end
      end
    end
  end

`ifdef FRAME_CHECK_ERRLOG_EN
  // The log captures only the first mismatch after reset and holds it until the next reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      first_err_vld <= 1'b0;
      first_err_exp <= '0;
      first_err_got <= '0;
      first_err_idx <= '0;
    end else if (beat && beat_err && !first_err_vld) begin
      first_err_vld <= 1'b1;
      first_err_exp <= exp_word;
      first_err_got <= s.tdata;
      first_err_idx <= beat_idx;
    end
  end
`else
  assign first_err_vld = 1'b0;
  assign first_err_exp = '0;
  assign first_err_got = '0;
  assign first_err_idx = '0;
`endif
endmodule

// File: tb/tb_frame_check.sv
`timescale 1ns/1ps
// Bench for frame_check. It drives directed and randomized frames and compares the outputs with a word-pointer model.
// The model takes the expected word of beat k as pattern word (base + k) mod 8. base advances by beats + SKIP_WORDS per frame.
module tb_frame_check;
  localparam int DW = 16, FRAME_LEN = 28, SKIP_WORDS = 28, CW = 16;
  localparam logic [127:0] PATTERN = 128'h0123_3210_2222_3333_4444_5555_beaf_dead;
`ifdef FRAME_CHECK_ERRLOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          link_up;
  logic [CW-1:0] frame_cnt, good_cnt, word_err_cnt, len_err_cnt;
  logic          frame_done, frame_ok, first_err_vld;
  logic [DW-1:0] first_err_exp, first_err_got;
  logic [6:0]    first_err_idx;

  frame_check_if #(.DW(DW)) s_if();

  frame_check #(
    .PATTERN(PATTERN), .DW(DW), .FRAME_LEN(FRAME_LEN), .SKIP_WORDS(SKIP_WORDS), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .link_up(link_up), .s(s_if),
    .frame_cnt(frame_cnt), .good_cnt(good_cnt), .word_err_cnt(word_err_cnt),
    .len_err_cnt(len_err_cnt), .frame_done(frame_done), .frame_ok(frame_ok),
    .first_err_vld(first_err_vld), .first_err_exp(first_err_exp),
    .first_err_got(first_err_got), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int base, gap;
  int m_frames, m_good, m_werr, m_lerr;
  bit m_log_vld;
  logic [15:0] m_log_exp, m_log_got;
  int m_log_idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat_word(input int i);
    logic [127:0] p;
    p = PATTERN;
    return p[16*(i % 8) +: 16];
  endfunction

  function automatic int msat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic check_counters(input string where);
    chk({where, ".frame_cnt"}, 32'(frame_cnt), 32'(m_frames));
    chk({where, ".good_cnt"}, 32'(good_cnt), 32'(m_good));
    chk({where, ".word_err_cnt"}, 32'(word_err_cnt), 32'(m_werr));
    chk({where, ".len_err_cnt"}, 32'(len_err_cnt), 32'(m_lerr));
    chk({where, ".first_err_vld"}, 32'(first_err_vld), 32'(LOG_EN && m_log_vld));
    chk({where, ".first_err_exp"}, 32'(first_err_exp), (LOG_EN && m_log_vld) ? 32'(m_log_exp) : 32'd0);
    chk({where, ".first_err_got"}, 32'(first_err_got), (LOG_EN && m_log_vld) ? 32'(m_log_got) : 32'd0);
    chk({where, ".first_err_idx"}, 32'(first_err_idx), (LOG_EN && m_log_vld) ? 32'(m_log_idx) : 32'd0);
  endtask

  task automatic do_reset(input string where);
    @(negedge clk);
    reset = 1'b1;
    link_up = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    base = SKIP_WORDS;
    m_frames = 0; m_good = 0; m_werr = 0; m_lerr = 0;
    m_log_vld = 1'b0; m_log_exp = '0; m_log_got = '0; m_log_idx = 0;
    chk({where, ".tready"}, 32'(s_if.tready), 32'd0);
    chk({where, ".frame_done"}, 32'(frame_done), 32'd0);
    chk({where, ".frame_ok"}, 32'(frame_ok), 32'd0);
    check_counters(where);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk({where, ".tready_release"}, 32'(s_if.tready), 32'd0);
    gap = 1;
  endtask

  // bad_kind: 1 = data 0xffff, 2 = tkeep 2'b01, 3 = random nonzero bit flip.
  // rnd adds tvalid gaps and link_up drops. no_last stops after n beats without closing the frame.
  task automatic send_frame(input string tag, input int n, input int bad_idx, input int bad_kind,
                            input bit rnd, input bit no_last);
    int k = 0;
    int guard = 0;
    bit ferr = 1'b0;
    bit ok;
    bit tv;
    logic [15:0] ew, d;
    logic [1:0] kp;
    while (k < n && guard < 20000) begin
      @(negedge clk);
      guard++;
      chk({tag, ".no_stray_done"}, 32'(frame_done), 32'd0);
      link_up = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
      tv = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      ew = pat_word(base + k);
      d = ew;
      kp = 2'b11;
      if (k == bad_idx) begin
        case (bad_kind)
          1: d = 16'hffff;
          2: kp = 2'b01;
          3: d = ew ^ 16'($urandom_range(1, 65535));
          default: ;
        endcase
      end
      s_if.tvalid = tv;
      s_if.tdata = d;
      s_if.tkeep = kp;
      s_if.tlast = !no_last && (k == n - 1);
      #1;
      if (k == 0 && tv && !s_if.tready) gap++;
      if (tv && s_if.tready) begin
        if (k == 0 && !rnd) chk({tag, ".skip_gap"}, 32'(gap), 32'(SKIP_WORDS));
        if (d !== ew || kp !== 2'b11) begin
          ferr = 1'b1;
          m_werr = msat(m_werr);
          if (!m_log_vld) begin
            m_log_vld = 1'b1;
            m_log_exp = ew;
            m_log_got = d;
            m_log_idx = (k > 127) ? 127 : k;
          end
        end
        k++;
      end
    end
    chk({tag, ".beat_budget"}, 32'(k), 32'(n));
    if (!no_last) begin
      // The tvalid signal stays asserted while the checker skips, so the tready gap is observable.
      @(negedge clk);
      s_if.tlast = 1'b0;
      link_up = 1'b1;
      #1;
      ok = !ferr && (n == FRAME_LEN);
      m_frames = msat(m_frames);
      if (ok) m_good = msat(m_good);
      if (n != FRAME_LEN) m_lerr = msat(m_lerr);
      base += n + SKIP_WORDS;
      chk({tag, ".frame_done"}, 32'(frame_done), 32'd1);
      chk({tag, ".frame_ok"}, 32'(frame_ok), 32'(ok));
      check_counters(tag);
      gap = s_if.tready ? 0 : 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    link_up = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    s_if.tkeep = 2'b11;
    s_if.tlast = 1'b0;

    do_reset("reset");
    send_frame("clean1", 28, -1, 0, 1'b0, 1'b0);
    send_frame("clean2_b2b", 28, -1, 0, 1'b0, 1'b0);
    send_frame("bad_beat5", 28, 5, 1, 1'b0, 1'b0);
    send_frame("short21", 21, -1, 0, 1'b0, 1'b0);
    send_frame("after_short", 28, -1, 0, 1'b0, 1'b0);
    send_frame("keep_beat0", 28, 0, 2, 1'b0, 1'b0);
    send_frame("long35", 35, -1, 0, 1'b0, 1'b0);
    send_frame("sat130", 130, 129, 3, 1'b0, 1'b0);

    for (int f = 0; f < 24; f++) begin
      int n;
      int bi;
      n = $urandom_range(20, 36);
      bi = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      send_frame("rand", n, bi, $urandom_range(1, 3), 1'b1, 1'b0);
    end
    send_frame("clean_after_rand", 28, -1, 0, 1'b0, 1'b0);

    send_frame("partial10", 10, -1, 0, 1'b0, 1'b1);
    do_reset("mid_reset");
    send_frame("clean_after_reset", 28, -1, 0, 1'b0, 1'b0);
    send_frame("err_after_reset", 28, 12, 3, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
